alu_op_sequencer: RTL and testbench

- Multi-cycle control sequencer that sits directly upstream of the 64-bit registered ALU.
- Accepts one register-to-register ALU instruction (opcode, ra, rb, rc) through a start/busy/done handshake.
- Steps the shared-bus datapath through four phases:
  - read ra into Y, the ALU A input;
  - read rb onto the bus, the ALU B input, and drive the ALU opcode;
  - write the low half of the result to rc, or to LO for mul/div;
  - write the high half to HI (mul/div only).

---
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer for the shared-bus 64-bit registered ALU.
// Runs one reg-to-reg instruction through read, execute and write-back phases.
module alu_op_sequencer #(
  parameter int REG_SEL_W = 4,
  parameter int OP_W      = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  input  logic [REG_SEL_W-1:0] ra,
  input  logic [REG_SEL_W-1:0] rb,
  input  logic [REG_SEL_W-1:0] rc,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [REG_SEL_W-1:0] rf_sel,
  output logic                 rf_out,
  output logic                 rf_in,
  output logic                 y_in,
  output logic [OP_W-1:0]      alu_op,
  output logic                 zlo_out,
  output logic                 zhi_out,
  output logic                 lo_in,
  output logic                 hi_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_DONE
  } state_e;

  localparam logic [OP_W-1:0] OP_MUL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NEG = OP_W'(12);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(15);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [REG_SEL_W-1:0] ra_q, ra_d;
  logic [REG_SEL_W-1:0] rb_q, rb_d;
  logic [REG_SEL_W-1:0] rc_q, rc_d;
  logic                 err_q, err_d;

  logic legal_op;
  logic unary_op;
  logic muldiv_q;

  assign legal_op = (op != '0) && (op <= OP_MAX);
  assign unary_op = (op == OP_NEG) || (op == OP_NOT);
  assign muldiv_q = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          ra_d  = ra;
          rb_d  = rb;
          rc_d  = rc;
          err_d = 1'b0;
          unique case (1'b1)
            !legal_op: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
            unary_op: state_d = S_T2;
            default:  state_d = S_T1;
          endcase
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = muldiv_q ? S_T4 : S_DONE;
      S_T4: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from the state register only.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    rf_sel  = '0;
    rf_out  = 1'b0;
    rf_in   = 1'b0;
    y_in    = 1'b0;
    alu_op  = '0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_T1: begin
        busy   = 1'b1;
        rf_sel = ra_q;
        rf_out = 1'b1;
        y_in   = 1'b1;
      end
      S_T2: begin
        busy   = 1'b1;
        rf_sel = rb_q;
        rf_out = 1'b1;
        alu_op = op_q;
      end
      S_T3: begin
        busy    = 1'b1;
        alu_op  = op_q;
        zlo_out = 1'b1;
        if (muldiv_q) begin
          lo_in = 1'b1;
        end else begin
          rf_sel = rc_q;
          rf_in  = 1'b1;
        end
      end
      S_T4: begin
        busy    = 1'b1;
        alu_op  = op_q;
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer.
// Each task compares the full output bundle cycle by cycle.
module tb_alu_op_sequencer;

  logic       clk;
  logic       clr;
  logic       start;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rf_sel;
  logic       rf_out;
  logic       rf_in;
  logic       y_in;
  logic [4:0] alu_op;
  logic       zlo_out;
  logic       zhi_out;
  logic       lo_in;
  logic       hi_in;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(
    .REG_SEL_W(4),
    .OP_W(5)
  ) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .op(op),
    .ra(ra),
    .rb(rb),
    .rc(rc),
    .busy(busy),
    .done(done),
    .err(err),
    .rf_sel(rf_sel),
    .rf_out(rf_out),
    .rf_in(rf_in),
    .y_in(y_in),
    .alu_op(alu_op),
    .zlo_out(zlo_out),
    .zhi_out(zhi_out),
    .lo_in(lo_in),
    .hi_in(hi_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy,done,err,rf_sel,rf_out,rf_in,y_in,alu_op,zlo,zhi,lo,hi}
  function automatic logic [18:0] outs();
    return {busy, done, err, rf_sel, rf_out, rf_in, y_in,
            alu_op, zlo_out, zhi_out, lo_in, hi_in};
  endfunction

  function automatic logic [18:0] pk(
    input logic b, input logic d, input logic e,
    input logic [3:0] sel, input logic ro, input logic ri,
    input logic yi, input logic [4:0] aop, input logic zl,
    input logic zh, input logic li, input logic hi);
    return {b, d, e, sel, ro, ri, yi, aop, zl, zh, li, hi};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c);
    start = 1'b1;
    op = o;
    ra = a;
    rb = b;
    rc = c;
    step();
    start = 1'b0;
    op = 5'd0;
    ra = 4'd0;
    rb = 4'd0;
    rc = 4'd0;
  endtask

  task automatic test_reset();
    logic [18:0] e[$];
    clr = 1'b1;
    start = 1'b1;
    op = 5'd1;
    ra = 4'd1;
    rb = 4'd2;
    rc = 4'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL reset cyc%0d got %h exp %h", i, outs(), 19'd0);
      end
    end
    clr = 1'b0;
    issue(5'd1, 4'd1, 4'd2, 4'd3);
    e.push_back(pk(1, 0, 0, 4'd1, 1, 0, 1, 5'd0, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd2, 1, 0, 0, 5'd1, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd3, 0, 1, 0, 5'd1, 1, 0, 0, 0));
    e.push_back(pk(1, 1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    e.push_back(19'd0);
    for (int i = 0; i < e.size(); i++) begin
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL add cyc%0d got %h exp %h", i, outs(), e[i]);
      end
      if (i < e.size() - 1) step();
    end
  endtask

  task automatic test_mul();
    logic [18:0] e[$];
    issue(5'd3, 4'd4, 4'd5, 4'd6);
    e.push_back(pk(1, 0, 0, 4'd4, 1, 0, 1, 5'd0, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd5, 1, 0, 0, 5'd3, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd0, 0, 0, 0, 5'd3, 1, 0, 1, 0));
    e.push_back(pk(1, 0, 0, 4'd0, 0, 0, 0, 5'd3, 0, 1, 0, 1));
    e.push_back(pk(1, 1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    e.push_back(19'd0);
    for (int i = 0; i < e.size(); i++) begin
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL mul cyc%0d got %h exp %h", i, outs(), e[i]);
      end
      if (i < e.size() - 1) step();
    end
  endtask

  task automatic test_unary();
    logic [18:0] e[$];
    issue(5'd12, 4'd5, 4'd7, 4'd8);
    e.push_back(pk(1, 0, 0, 4'd7, 1, 0, 0, 5'd12, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd8, 0, 1, 0, 5'd12, 1, 0, 0, 0));
    e.push_back(pk(1, 1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    e.push_back(19'd0);
    for (int i = 0; i < e.size(); i++) begin
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL neg cyc%0d got %h exp %h", i, outs(), e[i]);
      end
      if (i < e.size() - 1) step();
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ops[2];
    logic [18:0] ed;
    ops[0] = 5'd0;
    ops[1] = 5'd20;
    ed = pk(1, 1, 1, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      issue(ops[k], 4'd1, 4'd2, 4'd3);
      checks++;
      if (outs() !== ed) begin
        errors++;
        $display("FAIL illegal op%0d got %h exp %h", ops[k], outs(), ed);
      end
      step();
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL illegal_idle op%0d got %h exp %h",
                 ops[k], outs(), 19'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e[$];
    start = 1'b1;
    op = 5'd1;
    ra = 4'd1;
    rb = 4'd2;
    rc = 4'd3;
    step();
    op = 5'd2;
    ra = 4'd9;
    rb = 4'd10;
    e.push_back(pk(1, 0, 0, 4'd1, 1, 0, 1, 5'd0, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd2, 1, 0, 0, 5'd1, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd3, 0, 1, 0, 5'd1, 1, 0, 0, 0));
    e.push_back(pk(1, 1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    e.push_back(19'd0);
    e.push_back(pk(1, 0, 0, 4'd9, 1, 0, 1, 5'd0, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd10, 1, 0, 0, 5'd2, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd3, 0, 1, 0, 5'd2, 1, 0, 0, 0));
    e.push_back(pk(1, 1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    e.push_back(19'd0);
    for (int i = 0; i < e.size(); i++) begin
      if (i == 6) start = 1'b0;
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL b2b cyc%0d got %h exp %h", i, outs(), e[i]);
      end
      if (i < e.size() - 1) step();
    end
    op = 5'd0;
    ra = 4'd0;
    rb = 4'd0;
    rc = 4'd0;
  endtask

  task automatic test_reset_t3();
    logic [18:0] e[$];
    issue(5'd4, 4'd1, 4'd2, 4'd3);
    e.push_back(pk(1, 0, 0, 4'd1, 1, 0, 1, 5'd0, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd2, 1, 0, 0, 5'd4, 0, 0, 0, 0));
    e.push_back(pk(1, 0, 0, 4'd0, 0, 0, 0, 5'd4, 1, 0, 1, 0));
    for (int i = 0; i < e.size(); i++) begin
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL div cyc%0d got %h exp %h", i, outs(), e[i]);
      end
      if (i < e.size() - 1) step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs() !== 19'd0) begin
        errors++;
        $display("FAIL div_abort cyc%0d got %h exp %h", i, outs(), 19'd0);
      end
      step();
    end
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0;
    op = 5'd0;
    ra = 4'd0;
    rb = 4'd0;
    rc = 4'd0;
    test_reset();
    test_mul();
    test_unary();
    test_illegal();
    test_back_to_back();
    test_reset_t3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
